// File: rtl/run_pattern_tx.sv
// run_pattern_tx: serial run-length bit generator feeding the detector's w
// input, with a registered predicted-hit flag aligned to each emitted bit.
module run_pattern_tx #(
    parameter int LEN_W      = 4,
    parameter int RUN_THRESH = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_bit,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             w,
    output logic             w_valid,
    output logic             run_hit,
    output logic             done
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [3:0]       THRESH  = 4'(RUN_THRESH);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    state_t           state, state_d;
    logic [LEN_W-1:0] remaining, remaining_d;
    logic [3:0]       run_cnt, run_cnt_d;
    logic             prev_valid, prev_valid_d;
    logic             w_d, w_valid_d, run_hit_d, done_d;
    logic             last_bit, accept, emit, emit_bit;

    // The bit currently on w is the final one of its command.
    assign last_bit  = (state == SEND) && (remaining == ONE_LEN);
    // Ready depends on state only; gating with reset_n keeps it low during reset.
    assign cmd_ready = reset_n && ((state == IDLE) || last_bit);
    assign accept    = cmd_valid && cmd_ready;

    // Next-state, next-output and run-tracking logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d      = state;
        remaining_d  = remaining;
        run_cnt_d    = run_cnt;
        prev_valid_d = prev_valid;
        w_d          = w;
        w_valid_d    = 1'b0;
        run_hit_d    = 1'b0;
        done_d       = 1'b0;
        emit         = 1'b0;
        emit_bit     = w;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_len != '0) begin
                        state_d     = SEND;
                        remaining_d = cmd_len;
                        emit        = 1'b1;
                        emit_bit    = cmd_bit;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (remaining > ONE_LEN) begin
                    remaining_d = remaining - ONE_LEN;
                    emit        = 1'b1;
                end else begin
                    done_d = 1'b1;
                    if (accept && (cmd_len != '0)) begin
                        remaining_d = cmd_len;
                        emit        = 1'b1;
                        emit_bit    = cmd_bit;
                    end else begin
                        state_d     = IDLE;
                        remaining_d = '0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = '0;
            end
        endcase

        // Run length continues across command boundaries and idle gaps.
        if (emit) begin
            w_d          = emit_bit;
            w_valid_d    = 1'b1;
            prev_valid_d = 1'b1;
            if (prev_valid && (emit_bit == w)) begin
                run_cnt_d = (run_cnt >= THRESH) ? THRESH : run_cnt + 4'd1;
            end else begin
                run_cnt_d = 4'd1;
            end
            run_hit_d = (run_cnt_d >= THRESH);
        end
    end

    // State and registered outputs; reset aborts any command in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            remaining  <= '0;
            run_cnt    <= 4'd0;
            prev_valid <= 1'b0;
            w          <= 1'b0;
            w_valid    <= 1'b0;
            run_hit    <= 1'b0;
            done       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state      <= state_d;
            remaining  <= remaining_d;
            run_cnt    <= run_cnt_d;
            prev_valid <= prev_valid_d;
            w          <= w_d;
            w_valid    <= w_valid_d;
            run_hit    <= run_hit_d;
            done       <= done_d;
        end
    end

endmodule

// File: doc/run_pattern_tx.md
Name: run_pattern_tx

Overview:
- Serial bit-stream generator that drives the single-bit `w` input of the team's consecutive-equal-bit detector (the sequence-detector FSM).
- Accepts run commands over a valid/ready handshake; each command is "emit bit B for L consecutive cycles". Commands chain back-to-back with no gap.
- Also outputs a predicted-hit flag so benches and self-test logic can check the detector against a known stream.

Parameters:
- LEN_W, 4, width of cmd_len; max run length 2^LEN_W-1 (15 at default).
- RUN_THRESH, 5, consecutive-equal-bit count at which run_hit asserts; legal range 2..15.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_bit  input  1  bit value to emit.
- cmd_len  input  LEN_W  number of cycles to emit cmd_bit (unsigned).
- w  output  1  serial data bit; this is the detector's w.
- w_valid  output  1  w carries a commanded bit this cycle.
- run_hit  output  1  current w is the RUN_THRESH-th or later consecutive equal valid bit.
- done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk deassert use):
  - Outputs: w=0, w_valid=0, run_hit=0, done=0, cmd_ready=0 while reset_n=0.
  - FSM goes to IDLE; remaining-count=0; run_cnt=0; prev_valid=0.
- Reset mid-run aborts the command immediately. No done pulse for an aborted command.
- All outputs are registered. cmd_ready is combinational from state only: 1 in IDLE, or in SEND when remaining==1. Never combinational from cmd_valid.
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready.
  - cmd_bit and cmd_len are sampled only at acceptance.
  - The first bit appears on w/w_valid in the cycle after acceptance (1-cycle latency).
- FSM states: IDLE, SEND.
  - IDLE, accept with len>=1 -> SEND. w=cmd_bit, w_valid=1, remaining=len.
  - IDLE, accept with len=0 -> stay IDLE. done=1 next cycle, no bit emitted, w_valid=0.
  - SEND, remaining>1 -> SEND. remaining decrements, w unchanged.
  - SEND, remaining==1, no accept -> IDLE. done=1 and w_valid=0 next cycle.
  - SEND, remaining==1, accept with len>=1 -> SEND with the new command. The new bit follows on the next cycle with no gap; done=1 in that same cycle.
  - SEND, remaining==1, accept with len=0 -> IDLE. done=1 next cycle.
  - Two consecutive done cycles are legal, e.g. after back-to-back completions.
- Idle w: holds the last emitted bit (0 after reset) with w_valid=0. Idle cycles do not affect run_cnt.
- Run tracking, updated only on cycles that emit a valid bit:
  - If prev_valid and the bit equals the previous valid bit, run_cnt increments, saturating at RUN_THRESH.
  - Otherwise run_cnt=1.
  - run_hit = w_valid && (run_cnt >= RUN_THRESH), aligned with w.
  - Runs continue across command boundaries and idle gaps when the bit is unchanged.
- Detector alignment: with this block driving the detector every cycle, the detector's z is 1 in the cycle after each run_hit cycle. Benches check this only for gap-free streams.
- Widths: remaining is LEN_W bits; run_cnt is 4 bits; no arithmetic wraps.
- cmd_len=2^LEN_W-1 is legal and emits exactly 15 bits.

Test Plan:
- Reset then idle 3 cycles -> w=0, w_valid=0, run_hit=0, done=0, cmd_ready=1 after reset_n rises.
- Command (bit=0, len=5) accepted at edge k -> w=0, w_valid=1 in cycles k+1..k+5; run_hit=1 only in k+5; done=1 in k+6; cmd_ready=1 from k+5.
- Back-to-back (1,3) then (1,4) with cmd_valid held -> 7 contiguous 1s with no w_valid gap; run_hit=1 on bits 5..7; done pulses after bit 3 and after bit 7.
- Alternating commands (0,4),(1,4),(0,1) -> run_hit never asserts; done=1 three times; driven into the detector, z stays 0.
- Command (1,0) in IDLE -> no w_valid, done=1 one cycle after acceptance, state stays IDLE; then (1,15) -> exactly 15 valid 1s, run_hit=1 on bits 5..15.
- reset_n pulled low during bit 3 of (0,8) -> outputs clear asynchronously, no done pulse; after release, command (0,5) -> run_hit only on its 5th bit (no carry-over of the run).
